// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_pkg: shared op_type / FSM encodings for the stack sequencer     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [2:0] {
    OP_PUSH    = 3'd0,
    OP_POP     = 3'd1,
    OP_PUSH_PC = 3'd2,
    OP_POP_PC  = 3'd3,
    OP_INT     = 3'd4,
    OP_RTI     = 3'd5
  } op_e;

  localparam logic [2:0] OP_LAST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_RUN = 2'd1,
    ST_POP_RUN  = 2'd2,
    ST_POP_DONE = 2'd3
  } state_e;

  function automatic logic is_push_op(input op_e op);
    return (op == OP_PUSH) || (op == OP_PUSH_PC) || (op == OP_INT);
  endfunction

  function automatic logic [31:0] word_count(input op_e op, input int unsigned pc_words);
    case (op)
      OP_PUSH, OP_POP:       word_count = 32'd1;
      OP_PUSH_PC, OP_POP_PC: word_count = pc_words;
      default:               word_count = pc_words + 32'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_word_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stack_word_cnt: down-counter of remaining stack accesses            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module stack_word_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_stack_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stack_seq: multi-word push/pop sequencer for a memory stack     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_stack_seq
  import mem_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 12,
  parameter int          PC_WORDS = 2,
  parameter int unsigned SP_INIT  = 2047
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [2:0]                 op_type,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W*PC_WORDS-1:0] pc_in,
  input  logic [3:0]                 flags_in,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_we,
  output logic                       mem_re,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic [DATA_W-1:0]          pop_data,
  output logic [DATA_W*PC_WORDS-1:0] pc_out,
  output logic [3:0]                 flags_out,
  output logic                       pop_valid,
  output logic                       pc_valid,
  output logic                       flags_valid,
  output logic [ADDR_W-1:0]          sp_out,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int PC_W  = DATA_W * PC_WORDS;
  localparam int SEQ_W = PC_W + DATA_W;
  localparam int CNT_W = $clog2(PC_WORDS + 2);
  localparam logic [ADDR_W-1:0] SP_RST = SP_INIT[ADDR_W-1:0];

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [SEQ_W-1:0]    sr_q, sr_d;
  logic [PC_W-1:0]     pc_acc_q, pc_acc_d;
  logic [3:0]          flags_acc_q, flags_acc_d;
  logic                first_q, first_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic [PC_W-1:0]     pc_out_q, pc_out_d;
  logic [3:0]          flags_out_q, flags_out_d;
  logic                pop_valid_q, pop_valid_d;
  logic                pc_valid_q, pc_valid_d;
  logic                flags_valid_q, flags_valid_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_unf_q, err_unf_d;

  op_e                 w_op;
  logic                w_req, w_push, w_ovf, w_unf, w_cap_flags;
  logic [31:0]         w_n;
  logic [SEQ_W-1:0]    w_seq;
  logic [PC_W-1:0]     w_pc_next;
  logic [CNT_W-1:0]    w_cnt_init;
  logic                cnt_load, cnt_dec, cnt_tc;

  assign w_op       = op_e'(op_type);
  assign w_req      = reset && op_valid && (state_q == ST_IDLE) && (op_type <= OP_LAST);
  assign w_push     = is_push_op(w_op);
  assign w_n        = word_count(w_op, PC_WORDS);
  assign w_ovf      = (32'(sp_q) + 32'd1) < w_n;
  assign w_unf      = (32'(sp_q) + w_n) > 32'(SP_INIT);
  assign w_cnt_init = CNT_W'(w_n - 32'd2);
  // Push sequence: PC words MS-first, then the zero-extended flags word.
  assign w_seq      = {pc_in, {(DATA_W-4){1'b0}}, flags_in};
  // PC words pop LS-first, so each new word enters at the top and shifts down.
  assign w_pc_next  = (pc_acc_q >> DATA_W) | (PC_W'(mem_rdata) << (PC_W - DATA_W));
  assign w_cap_flags = first_q && (op_q == OP_RTI);

  stack_word_cnt #(.W(CNT_W)) u_word_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (w_cnt_init),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    sp_d          = sp_q;
    sr_d          = sr_q;
    pc_acc_d      = pc_acc_q;
    flags_acc_d   = flags_acc_q;
    first_d       = first_q;
    pop_data_d    = pop_data_q;
    pc_out_d      = pc_out_q;
    flags_out_d   = flags_out_q;
    pop_valid_d   = 1'b0;
    pc_valid_d    = 1'b0;
    flags_valid_d = 1'b0;
    err_ovf_d     = 1'b0;
    err_unf_d     = 1'b0;
    mem_addr      = sp_q;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_req && w_push) begin
          if (w_ovf) begin
            err_ovf_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = (w_op == OP_PUSH) ? wr_data : w_seq[SEQ_W-1 -: DATA_W];
            sp_d      = sp_q - ADDR_W'(1);
            op_d      = w_op;
            sr_d      = w_seq << DATA_W;
            if (w_n > 32'd1) begin
              state_d  = ST_PUSH_RUN;
              cnt_load = 1'b1;
            end
          end
        end else if (w_req) begin
          if (w_unf) begin
            err_unf_d = 1'b1;
          end else begin
            mem_re   = 1'b1;
            mem_addr = sp_q + ADDR_W'(1);
            sp_d     = sp_q + ADDR_W'(1);
            op_d     = w_op;
            first_d  = 1'b1;
            if (w_n > 32'd1) begin
              state_d  = ST_POP_RUN;
              cnt_load = 1'b1;
            end else begin
              state_d  = ST_POP_DONE;
            end
          end
        end
      end

      ST_PUSH_RUN: begin
        mem_we    = 1'b1;
        mem_wdata = sr_q[SEQ_W-1 -: DATA_W];
        sr_d      = sr_q << DATA_W;
        sp_d      = sp_q - ADDR_W'(1);
        if (cnt_tc) state_d = ST_IDLE;
        else        cnt_dec = 1'b1;
      end

      ST_POP_RUN: begin
        mem_re   = 1'b1;
        mem_addr = sp_q + ADDR_W'(1);
        sp_d     = sp_q + ADDR_W'(1);
        first_d  = 1'b0;
        if (w_cap_flags) flags_acc_d = mem_rdata[3:0];
        else             pc_acc_d    = w_pc_next;
        if (cnt_tc) state_d = ST_POP_DONE;
        else        cnt_dec = 1'b1;
      end

      ST_POP_DONE: begin
        state_d = ST_IDLE;
        first_d = 1'b0;
        if (op_q == OP_POP) begin
          pop_data_d  = mem_rdata;
          pop_valid_d = 1'b1;
        end else begin
          pc_acc_d   = w_pc_next;
          pc_out_d   = w_pc_next;
          pc_valid_d = 1'b1;
          if (op_q == OP_RTI) begin
            flags_out_d   = flags_acc_q;
            flags_valid_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_PUSH;
      sp_q          <= SP_RST;
      sr_q          <= '0;
      pc_acc_q      <= '0;
      flags_acc_q   <= '0;
      first_q       <= 1'b0;
      pop_data_q    <= '0;
      pc_out_q      <= '0;
      flags_out_q   <= '0;
      pop_valid_q   <= 1'b0;
      pc_valid_q    <= 1'b0;
      flags_valid_q <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_unf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      sp_q          <= sp_d;
      sr_q          <= sr_d;
      pc_acc_q      <= pc_acc_d;
      flags_acc_q   <= flags_acc_d;
      first_q       <= first_d;
      pop_data_q    <= pop_data_d;
      pc_out_q      <= pc_out_d;
      flags_out_q   <= flags_out_d;
      pop_valid_q   <= pop_valid_d;
      pc_valid_q    <= pc_valid_d;
      flags_valid_q <= flags_valid_d;
      err_ovf_q     <= err_ovf_d;
      err_unf_q     <= err_unf_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign sp_out      = sp_q;
  assign pop_data    = pop_data_q;
  assign pc_out      = pc_out_q;
  assign flags_out   = flags_out_q;
  assign pop_valid   = pop_valid_q;
  assign pc_valid    = pc_valid_q;
  assign flags_valid = flags_valid_q;
  assign err_ovf     = err_ovf_q;
  assign err_unf     = err_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stack_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_stack_seq: directed self-checking bench for mem_stack_seq    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mem_stack_seq;

  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, PUSH_PC = 3'd2,
                         POP_PC = 3'd3, INT = 3'd4, RTI = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [15:0] wr_data;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic [15:0] pop_data;
  logic [31:0] pc_out;
  logic [3:0]  flags_out;
  logic        pop_valid, pc_valid, flags_valid;
  logic [11:0] sp_out;
  logic        err_ovf, err_unf;

  logic [15:0] mem [0:4095];
  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0, re_cnt = 0, both_cnt = 0, pcv_cnt = 0;
  int snap;

  mem_stack_seq dut (
    .clk(clk), .reset(rst_n), .op_valid(op_valid), .op_type(op_type),
    .wr_data(wr_data), .pc_in(pc_in), .flags_in(flags_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .pop_data(pop_data), .pc_out(pc_out),
    .flags_out(flags_out), .pop_valid(pop_valid), .pc_valid(pc_valid),
    .flags_valid(flags_valid), .sp_out(sp_out), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) we_cnt++;
    if (mem_re) re_cnt++;
    if (mem_we && mem_re) both_cnt++;
    if (pc_valid) pcv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] wd,
                       input logic [31:0] pc, input logic [3:0] fl);
    op_valid = 1'b1;
    op_type  = op;
    wr_data  = wd;
    pc_in    = pc;
    flags_in = fl;
  endtask

  task automatic idle();
    op_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    rst_n = 1'b0;
    idle();
    op_type = 3'd0; wr_data = '0; pc_in = '0; flags_in = '0;
    repeat (3) tick();
    check("rst_sp", sp_out, 12'd2047);
    check("rst_busy", busy, 1'b0);
    check("rst_outs", {pop_data, pc_out, flags_out}, 52'h0);
    check("rst_strobes", {pop_valid, pc_valid, flags_valid, err_ovf, err_unf, mem_we, mem_re}, 7'h0);
    rst_n = 1'b1;
    tick();

    // Single PUSH then POP
    issue(PUSH, 16'hA5A5, '0, '0); #1;
    check("push_we", {mem_we, mem_re, mem_addr, mem_wdata}, {2'b10, 12'd2047, 16'hA5A5});
    check("push_busy0", busy, 1'b0);
    tick(); idle(); #1;
    check("push_sp", sp_out, 12'd2046);
    check("push_mem", mem[2047], 16'hA5A5);
    check("push_nobusy", busy, 1'b0);
    issue(POP, '0, '0, '0); #1;
    check("pop_re", {mem_we, mem_re, mem_addr}, {2'b01, 12'd2047});
    tick(); idle(); #1;
    check("pop_t1", {busy, pop_valid, mem_re}, 3'b100);
    tick();
    check("pop_t2", {pop_valid, pop_data, busy}, {1'b1, 16'hA5A5, 1'b0});
    check("pop_sp", sp_out, 12'd2047);
    tick();
    check("pop_hold", {pop_valid, pop_data}, {1'b0, 16'hA5A5});

    // INT, with a request during busy that must be ignored
    issue(INT, '0, 32'h0001_2345, 4'hB); #1;
    check("int_w0", {mem_we, mem_addr, mem_wdata}, {1'b1, 12'd2047, 16'h0001});
    tick(); issue(PUSH, 16'h1111, '0, '0); #1;
    check("int_w1", {busy, mem_we, mem_addr, mem_wdata}, {2'b11, 12'd2046, 16'h2345});
    tick(); idle(); #1;
    check("int_w2", {busy, mem_we, mem_addr, mem_wdata}, {2'b11, 12'd2045, 16'h000B});
    tick(); #1;
    check("int_end", {busy, mem_we, sp_out}, {2'b00, 12'd2044});
    check("int_mem", {mem[2047], mem[2046], mem[2045]}, {16'h0001, 16'h2345, 16'h000B});

    // RTI
    issue(RTI, '0, '0, '0); #1;
    check("rti_r0", {mem_re, mem_addr}, {1'b1, 12'd2045});
    tick(); idle(); #1;
    check("rti_r1", {busy, mem_re, mem_addr}, {2'b11, 12'd2046});
    tick(); #1;
    check("rti_r2", {busy, mem_re, mem_addr}, {2'b11, 12'd2047});
    tick(); #1;
    check("rti_t3", {busy, mem_re, pc_valid, flags_valid}, 4'b1000);
    tick();
    check("rti_t4", {pc_valid, flags_valid, pop_valid, busy}, 4'b1100);
    check("rti_data", {pc_out, flags_out}, {32'h0001_2345, 4'hB});
    check("rti_sp", sp_out, 12'd2047);
    tick();
    check("rti_t5", {pc_valid, flags_valid}, 2'b00);

    // POP on empty stack
    snap = re_cnt;
    issue(POP, '0, '0, '0); #1;
    check("unf_nore", mem_re, 1'b0);
    tick(); idle(); #1;
    check("unf_t1", {err_unf, busy, sp_out}, {2'b10, 12'd2047});
    tick();
    check("unf_t2", {err_unf, pop_valid}, 2'b00);
    check("unf_reads", re_cnt, snap);

    // RTI with only one word on the stack
    issue(PUSH, 16'h7777, '0, '0);
    tick(); issue(RTI, '0, '0, '0); #1;
    check("rti_unf_nore", mem_re, 1'b0);
    tick(); idle(); #1;
    check("rti_unf", {err_unf, busy, flags_valid, sp_out}, {3'b100, 12'd2046});
    issue(POP, '0, '0, '0);
    tick(); idle(); tick(); tick();
    check("pop_7777", {pop_data, sp_out}, {16'h7777, 12'd2047});

    // Reserved op_type is no request
    snap = we_cnt;
    issue(3'd6, 16'h5555, '0, '0);
    tick(); idle();
    check("op6_ign", {busy, sp_out}, {1'b0, 12'd2047});
    check("op6_nowr", we_cnt, snap);

    // PUSH_PC / POP_PC round trip
    issue(PUSH_PC, '0, 32'hDEAD_BEEF, '0); #1;
    check("ppc_w0", {mem_we, mem_wdata}, {1'b1, 16'hDEAD});
    tick(); idle(); #1;
    check("ppc_w1", {busy, mem_we, mem_addr, mem_wdata}, {2'b11, 12'd2046, 16'hBEEF});
    tick();
    check("ppc_sp", {busy, sp_out}, {1'b0, 12'd2045});
    issue(POP_PC, '0, '0, '0);
    tick(); idle(); tick(); tick();
    check("popc", {pc_valid, pop_valid, flags_valid, pc_out}, {3'b100, 32'hDEAD_BEEF});
    check("popc_sp", sp_out, 12'd2047);

    // Reset in the middle of POP_PC
    issue(PUSH_PC, '0, 32'hCAFE_F00D, '0);
    tick(); idle(); tick();
    issue(POP_PC, '0, '0, '0);
    tick(); idle();
    snap = pcv_cnt;
    rst_n = 1'b0; #1;
    check("abort", {sp_out, busy, mem_re, mem_we}, {12'd2047, 3'b000});
    tick(); rst_n = 1'b1;
    repeat (4) tick();
    check("abort_nopcv", pcv_cnt, snap);
    check("abort_pcout", {pc_out, sp_out}, {32'h0, 12'd2047});

    // Fill to SP=0, then PUSH_PC must overflow
    issue(PUSH, '0, '0, '0);
    for (int i = 0; i < 2047; i++) begin
      wr_data = 16'(i);
      tick();
    end
    idle();
    check("fill_sp", sp_out, 12'd0);
    check("fill_mem1", mem[1], 16'd2046);
    snap = we_cnt;
    issue(PUSH_PC, '0, 32'h1234_5678, '0); #1;
    check("ovf_nowe", mem_we, 1'b0);
    tick(); idle(); #1;
    check("ovf_t1", {err_ovf, busy, sp_out}, {2'b10, 12'd0});
    tick();
    check("ovf_t2", err_ovf, 1'b0);
    check("ovf_nowr", we_cnt, snap);
    check("ovf_mem0", mem[0], 16'h0000);

    check("we_re_excl", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
